// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one shared full_adder cell adds two WIDTH-bit operands
// LSB first, one bit per clock, then holds the registered result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] psum;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] next_psum;

  full_adder u_fa (
    .a     (sa[0]),
    .b     (sb[0]),
    .cin   (c),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Each sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign next_psum = {fa_sum, psum[WIDTH-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: every register here, the datapath included, is cleared by rst_n so
  // an aborted operation leaves no stale operand or carry behind; all state
  // uses non-blocking assignments so the shift chain reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      psum    <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a_in;
            sb    <= b_in;
            c     <= cin_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa   <= {1'b0, sa[WIDTH-1:1]};
          sb   <= {1'b0, sb[WIDTH-1:1]};
          psum <= next_psum;
          c    <= fa_carry;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum_out <= next_psum;
            cout    <= fa_carry;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low (fixed); synchronous deassert at the system level.
REQ-004 start  input  1  request to add; sampled on rising clk edge, accepted only in IDLE.
REQ-005 a_in  input  WIDTH  operand A, captured when start is accepted.
REQ-006 b_in  input  WIDTH  operand B, captured when start is accepted.
REQ-007 cin_in  input  1  initial carry-in, captured when start is accepted.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 sum_out  output  WIDTH  registered sum, held between operations.
REQ-011 cout  output  1  registered final carry-out, held between operations.

Function
REQ-012 The block SHALL instantiate the team's existing full_adder cell (ports a, b, cin, sum, carry) exactly once as its only arithmetic element; no WIDTH-bit "+" operator.
REQ-013 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-014 IDLE: on an edge with start=1, load shift registers SA<=a_in and SB<=b_in, carry register C<=cin_in, bit counter<=0, and go to RUN.
REQ-015 IDLE with start=0: remain in IDLE, with no register changes.
REQ-016 RUN: the full_adder inputs SHALL be SA[0], SB[0] and C, processed LSB first.
REQ-017 RUN, each edge: shift SA and SB right by one, shift the full_adder sum into the MSB of the partial-sum register, load C<=full_adder carry, and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH edges; on the edge where counter=WIDTH-1, copy the completed sum to sum_out and the new carry to cout, then go to DONE.
REQ-019 DONE SHALL last exactly one cycle, with done=1 and busy=0, then go to IDLE unconditionally.
REQ-020 Latency: if start is accepted at edge E0, done SHALL be high during the cycle after edge E0+WIDTH, and sum_out/cout SHALL be valid from E0+WIDTH onward.
REQ-021 start SHALL be ignored in RUN and DONE; captured operands are not disturbed; a_in, b_in and cin_in changes after acceptance SHALL have no effect.
REQ-022 sum_out and cout SHALL not change during RUN; they update only at the final RUN edge, or on reset.
REQ-023 Arithmetic: {cout,sum_out} SHALL equal a_in + b_in + cin_in modulo 2^(WIDTH+1) for all operand values, including all-ones wrap-around.
REQ-024 Back-to-back: start held high continuously SHALL give one operation per WIDTH+2 cycles (accept, WIDTH run edges, DONE).
REQ-025 busy and done SHALL never be high at the same time.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum_out=0, cout=0, and clear the counter, shift registers and C.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept a new start normally.
REQ-028 On the first edge after rst_n rises, the block SHALL accept start if it is high.

Verification
REQ-029 WIDTH=8, a=0x00, b=0x00, cin=0 -> sum_out=0x00, cout=0, done exactly 9 edges after the accept edge, with busy high for 8 cycles.
REQ-030 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout=1.
REQ-031 WIDTH=8, a=0x5A, b=0x3C, cin=0 -> sum_out=0x96, cout=0; a_in/b_in changed to 0x00 on the cycle after accept -> result unchanged.
REQ-032 start pulsed again at cycle 3 of RUN -> ignored, a single done pulse, and the prior sum_out stays stable until the final RUN edge.
REQ-033 rst_n pulsed low at RUN cycle 4 -> outputs 0 immediately, no done pulse; a following start with a=0x01, b=0x02, cin=1 -> sum_out=0x04, cout=0.
REQ-034 WIDTH=3: exhaustive sweep of all 128 a/b/cin combinations, back-to-back with start held high -> every result matches a golden a+b+cin, with done spacing of 5 cycles.
